// File: rtl/ysyx_22050710_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and
// default bus widths.
package ysyx_22050710_mem_pkg;

  localparam int DEF_AW = 64;
  localparam int DEF_DW = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_22050710_mem_arb_if.sv
// Bus bundle around the arbiter: IF requester, LS requester and memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ysyx_22050710_mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;

  logic            ls_req;
  logic            ls_wen;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wmask;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_req;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  logic            err;

  modport slave (
    input  if_req, if_addr, ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
           mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, err
  );

  modport master (
    output if_req, if_addr, ls_req, ls_wen, ls_addr, ls_wdata, ls_wmask,
           mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, err
  );
endinterface

// File: rtl/ysyx_22050710_rr_arb2.sv
// Two-way round-robin arbiter; req[0] is IF, req[1] is LS.
// Priority only moves on a contested grant, and then goes to the loser.
module ysyx_22050710_rr_arb2
  import ysyx_22050710_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_t prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || prio == OWN_IF)) gnt = 2'b01;
      else if (req[1])                          gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                prio <= OWN_IF;
    else if (en && (&req))  prio <= gnt[0] ? OWN_LS : OWN_IF;
  end

endmodule

// File: rtl/ysyx_22050710_mem_arb.sv
// Shares one memory port between instruction fetch and load/store, one access
// at a time, with an ack timeout that completes the access with o_err.
//
//   state  | meaning
//   S_IDLE | grant one requester, latch its command
//   S_WAIT | drive mem request until ack or timeout
//   S_RESP | one-cycle rvalid (and err on timeout) to the owner
module ysyx_22050710_mem_arb
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ysyx_22050710_mem_arb_if.slave bus
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  owner_t          owner;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [MW-1:0]   wmask_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            err_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   ls_rdata_q;
  logic [DW-1:0]   rdata_cap;
  logic [1:0]      gnt;
  logic            arb_en;
  logic            timeout_hit;
  logic            in_wait;
  logic            in_resp;

  assign arb_en      = (state == S_IDLE) && !i_rst;
  assign in_wait     = (state == S_WAIT);
  assign in_resp     = (state == S_RESP);
  assign cnt_inc     = cnt + CW'(1);
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));
  assign rdata_cap   = wen_q ? '0 : bus.mem_rdata;

  ysyx_22050710_rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .en  (arb_en),
    .req ({bus.ls_req, bus.if_req}),
    .gnt (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|gnt) state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_ack || timeout_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (gnt[0]) begin
            owner   <= OWN_IF;
            addr_q  <= bus.if_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '1;
          end else if (gnt[1]) begin
            owner   <= OWN_LS;
            addr_q  <= bus.ls_addr;
            wen_q   <= bus.ls_wen;
            wdata_q <= bus.ls_wdata;
            wmask_q <= bus.ls_wmask;
          end
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          // an ack on the timeout cycle still wins: normal completion
          if (bus.mem_ack) begin
            err_q <= 1'b0;
            if (owner == OWN_IF) if_rdata_q <= rdata_cap;
            else                 ls_rdata_q <= rdata_cap;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (owner == OWN_IF) if_rdata_q <= '0;
            else                 ls_rdata_q <= '0;
          end
        end
        S_RESP: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = gnt[0];
  assign bus.ls_gnt    = gnt[1];
  assign bus.mem_req   = in_wait;
  assign bus.mem_wen   = in_wait & wen_q;
  assign bus.mem_addr  = in_wait ? addr_q  : '0;
  assign bus.mem_wdata = in_wait ? wdata_q : '0;
  assign bus.mem_wmask = in_wait ? wmask_q : '0;
  assign bus.if_rvalid = in_resp && (owner == OWN_IF);
  assign bus.ls_rvalid = in_resp && (owner == OWN_LS);
  assign bus.err       = in_resp && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule
